// File: rtl/cp_pkg.sv
// rtl/cp_pkg.sv - shared types for the charge-pump phase controller
package cp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOFT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } cp_state_t;

endpackage

// File: rtl/cp_sync2.sv
// rtl/cp_sync2.sv - two-flop synchroniser with asynchronous active-low reset
module cp_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cp_phase_ctrl.sv
// rtl/cp_phase_ctrl.sv - non-overlapping multi-phase charge-pump clock controller
module cp_phase_ctrl
  import cp_pkg::*;
#(
  parameter int NPHASE = 2,
  parameter int DIV_W  = 8,
  parameter int DEAD   = 1,
  parameter int SS_ROT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DIV_W-1:0]  div,
  input  logic              regulate,
  input  logic              cmp_in,
  output logic [NPHASE-1:0] phi,
  output logic              pump_on,
  output logic              ready
);

  localparam int CW = DIV_W + 2;
  localparam int IW = $clog2(NPHASE);
  localparam int RW = $clog2(SS_ROT + 1);

  cp_state_t         state_q, state_d;
  logic              on_q, on_d;
  logic              gap_q, gap_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     rot_q, rot_d;
  logic [NPHASE-1:0] phi_q, phi_d;
  logic              pump_on_q, pump_on_d;
  logic              ready_q, ready_d;
  logic              cmp_s;
  logic              start;
  logic              last_idx;
  logic [IW-1:0]     idx_nxt;

  cp_sync2 #(.W(1)) u_cmp_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (cmp_in),
    .q_o    (cmp_s)
  );

  assign last_idx = (idx_q == IW'(NPHASE - 1));
  assign idx_nxt  = last_idx ? '0 : idx_q + 1'b1;

  // A cycle with neither on_q nor gap_q set is a lead-in: the next edge opens slot idx_q.
  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rot_d   = rot_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        on_d  = 1'b0;
        gap_d = 1'b0;
        cnt_d = '0;
        idx_d = '0;
        rot_d = '0;
        if (ena) state_d = ST_SOFT;
      end
      ST_SOFT, ST_RUN: begin
        if (on_q) begin
          if (cnt_q == '0) begin
            on_d  = 1'b0;
            gap_d = 1'b1;
            cnt_d = CW'(DEAD - 1);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end else if (gap_q) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            gap_d = 1'b0;
            idx_d = idx_nxt;
            if (!ena) begin
              state_d = ST_IDLE;
            end else if (state_q == ST_SOFT) begin
              if (last_idx) begin
                rot_d = rot_q + 1'b1;
                if (rot_q == RW'(SS_ROT - 1)) state_d = ST_RUN;
              end
              start = 1'b1;
            end else if (regulate && cmp_s) begin
              state_d = ST_HOLD;
            end else begin
              start = 1'b1;
            end
          end
        end else begin
          if (!ena) state_d = ST_IDLE;
          else      start   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!ena)                      state_d = ST_IDLE;
        else if (!regulate || !cmp_s)  state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    // Soft start doubles the ON time: 2*(div+1)-1 = {div,1}.
    if (start) begin
      on_d  = 1'b1;
      cnt_d = (state_d == ST_SOFT) ? CW'({div, 1'b1}) : CW'(div);
    end

    phi_d     = on_d ? (NPHASE'(1) << idx_d) : '0;
    pump_on_d = (state_d == ST_SOFT) || (state_d == ST_RUN);
    ready_d   = (state_d == ST_RUN) || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      on_q      <= 1'b0;
      gap_q     <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      rot_q     <= '0;
      phi_q     <= '0;
      pump_on_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_q      <= on_d;
      gap_q     <= gap_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rot_q     <= rot_d;
      phi_q     <= phi_d;
      pump_on_q <= pump_on_d;
      ready_q   <= ready_d;
    end
  end

  assign phi     = phi_q;
  assign pump_on = pump_on_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_cp_phase_ctrl.sv
// tb/tb_cp_phase_ctrl.sv - self-checking bench for cp_phase_ctrl
module tb_cp_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] div = 8'd3;
  logic       regulate = 1'b0;
  logic       cmp_in = 1'b0;
  logic [1:0] phi;
  logic       pump_on;
  logic       ready;

  logic       ena4 = 1'b0;
  logic [7:0] div4 = 8'd2;
  logic       reg4 = 1'b0;
  logic       cmp4 = 1'b0;
  logic [3:0] phi4;
  logic       pump4;
  logic       rdy4;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cp_phase_ctrl #(.NPHASE(2), .DIV_W(8), .DEAD(1), .SS_ROT(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .div(div), .regulate(regulate),
    .cmp_in(cmp_in), .phi(phi), .pump_on(pump_on), .ready(ready)
  );

  cp_phase_ctrl #(.NPHASE(4), .DIV_W(8), .DEAD(2), .SS_ROT(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena4), .div(div4), .regulate(reg4),
    .cmp_in(cmp4), .phi(phi4), .pump_on(pump4), .ready(rdy4)
  );

  typedef struct {
    int         cyc;
    logic       ena;
    logic [7:0] div;
    logic [1:0] phi;
    logic       pump;
    logic       rdy;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance one cycle and compare {phi, pump_on, ready} as one packed value.
  task automatic expect_cyc(input string nm, input logic [1:0] ephi, input logic ep, input logic er);
    step();
    chk(nm, int'({phi, pump_on, ready}), int'({ephi, ep, er}));
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int cur;
    bit got;

    tbl[0]  = '{0,  1'b1, 8'd3, 2'b00, 1'b1, 1'b0};
    tbl[1]  = '{1,  1'b1, 8'd3, 2'b01, 1'b1, 1'b0};
    tbl[2]  = '{8,  1'b1, 8'd3, 2'b01, 1'b1, 1'b0};
    tbl[3]  = '{9,  1'b1, 8'd3, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{10, 1'b1, 8'd3, 2'b10, 1'b1, 1'b0};
    tbl[5]  = '{17, 1'b1, 8'd3, 2'b10, 1'b1, 1'b0};
    tbl[6]  = '{18, 1'b1, 8'd3, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{19, 1'b1, 8'd3, 2'b01, 1'b1, 1'b0};
    tbl[8]  = '{36, 1'b1, 8'd3, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{37, 1'b1, 8'd3, 2'b01, 1'b1, 1'b1};
    tbl[10] = '{40, 1'b1, 8'd3, 2'b01, 1'b1, 1'b1};
    tbl[11] = '{41, 1'b1, 8'd3, 2'b00, 1'b1, 1'b1};
    tbl[12] = '{42, 1'b1, 8'd3, 2'b10, 1'b1, 1'b1};
    tbl[13] = '{45, 1'b1, 8'd3, 2'b10, 1'b1, 1'b1};
    tbl[14] = '{46, 1'b1, 8'd3, 2'b00, 1'b1, 1'b1};

    step();
    step();
    chk("reset_outputs", int'({phi, pump_on, ready, phi4, pump4, rdy4}), 0);

    // Soft start: ena high before release so the first edge after release is edge 0.
    ena = 1'b1;
    div = 8'd3;
    rst_n = 1'b1;
    cur = -1;
    for (int r = 0; r < 15; r++) begin
      while (cur < tbl[r].cyc) begin
        ena = tbl[r].ena;
        div = tbl[r].div;
        step();
        cur++;
      end
      chk($sformatf("soft_start_c%0d", tbl[r].cyc), int'({phi, pump_on, ready}),
          int'({tbl[r].phi, tbl[r].pump, tbl[r].rdy}));
    end

    // div 3 -> 0 in the middle of a segment
    expect_cyc("div_c47", 2'b01, 1'b1, 1'b1);
    expect_cyc("div_c48", 2'b01, 1'b1, 1'b1);
    div = 8'd0;
    expect_cyc("div_c49", 2'b01, 1'b1, 1'b1);
    expect_cyc("div_c50", 2'b01, 1'b1, 1'b1);
    expect_cyc("div_c51", 2'b00, 1'b1, 1'b1);
    expect_cyc("div_c52", 2'b10, 1'b1, 1'b1);
    expect_cyc("div_c53", 2'b00, 1'b1, 1'b1);
    expect_cyc("div_c54", 2'b01, 1'b1, 1'b1);
    expect_cyc("div_c55", 2'b00, 1'b1, 1'b1);
    div = 8'd3;
    expect_cyc("div_c56", 2'b10, 1'b1, 1'b1);

    // Regulation: the running slot and its gap complete, then hold
    regulate = 1'b1;
    cmp_in = 1'b1;
    expect_cyc("reg_c57", 2'b10, 1'b1, 1'b1);
    expect_cyc("reg_c58", 2'b10, 1'b1, 1'b1);
    expect_cyc("reg_c59", 2'b10, 1'b1, 1'b1);
    expect_cyc("reg_c60", 2'b00, 1'b1, 1'b1);
    for (int c = 61; c <= 66; c++) expect_cyc($sformatf("hold_c%0d", c), 2'b00, 1'b0, 1'b1);
    cmp_in = 1'b0;
    expect_cyc("hold_exit_t", 2'b00, 1'b0, 1'b1);
    expect_cyc("hold_exit_t1", 2'b00, 1'b0, 1'b1);
    expect_cyc("hold_exit_t2", 2'b00, 1'b1, 1'b1);
    expect_cyc("hold_exit_t3", 2'b01, 1'b1, 1'b1);

    // ena drop on the second cycle of a 4-cycle RUN segment
    regulate = 1'b0;
    ena = 1'b0;
    expect_cyc("ena_off_c71", 2'b01, 1'b1, 1'b1);
    expect_cyc("ena_off_c72", 2'b01, 1'b1, 1'b1);
    expect_cyc("ena_off_c73", 2'b01, 1'b1, 1'b1);
    expect_cyc("ena_off_gap", 2'b00, 1'b1, 1'b1);
    expect_cyc("ena_off_idle", 2'b00, 1'b0, 1'b0);
    expect_cyc("ena_off_idle2", 2'b00, 1'b0, 1'b0);
    ena = 1'b1;
    expect_cyc("reen_lead", 2'b00, 1'b1, 1'b0);
    for (int c = 78; c <= 85; c++) expect_cyc($sformatf("reen_c%0d", c), 2'b01, 1'b1, 1'b0);
    expect_cyc("reen_gap", 2'b00, 1'b1, 1'b0);
    expect_cyc("reen_phi1", 2'b10, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a RUN segment
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      step();
      got = (ready == 1'b1);
    end
    chk("wait_run_reached", int'(got), 1);
    step();
    chk("pre_reset_active", int'(phi != 2'b00), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_clear", int'({phi, pump_on, ready}), 0);
    ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_cyc("post_reset_idle", 2'b00, 1'b0, 1'b0);
    ena = 1'b1;
    expect_cyc("post_reset_lead", 2'b00, 1'b1, 1'b0);
    expect_cyc("post_reset_idx0", 2'b01, 1'b1, 1'b0);
    ena = 1'b0;

    // NPHASE=4, DEAD=2: random traffic checked against slot-level rules
    begin
      bit   prev_on = 1'b0;
      bit   was_soft = 1'b0;
      int   gap_len = 100;
      int   run_len = 0;
      int   exp_len = 0;
      int   exp_idx = 0;
      int   soft_cnt = 0;
      int   seg_cnt = 0;
      int   run_segs = 0;
      logic [3:0] seg_phi = '0;
      ena4 = 1'b1;
      for (int c = 0; c < 3000; c++) begin
        step();
        chk("p4_onehot_pump", int'($onehot0(phi4) && (phi4 == 4'd0 || pump4)), 1);
        if (!pump4 && !rdy4) begin
          exp_idx = 0;
          soft_cnt = 0;
          was_soft = 1'b0;
        end
        if (phi4 != 4'd0) begin
          if (!prev_on) begin
            seg_cnt++;
            chk("p4_dead_gap", int'(gap_len >= 2), 1);
            chk("p4_order", idx_of(phi4), exp_idx);
            seg_phi = phi4;
            run_len = 1;
            exp_len = rdy4 ? int'(div4) + 1 : 2 * (int'(div4) + 1);
            if (rdy4) begin
              run_segs++;
              if (was_soft) chk("p4_soft_segments", soft_cnt, 8);
              was_soft = 1'b0;
            end else begin
              soft_cnt++;
              was_soft = 1'b1;
            end
          end else begin
            chk("p4_phase_stable", int'(phi4), int'(seg_phi));
            run_len++;
          end
          gap_len = 0;
        end else begin
          if (prev_on) begin
            chk("p4_seg_len", run_len, exp_len);
            exp_idx = (idx_of(seg_phi) + 1) % 4;
          end
          gap_len++;
        end
        prev_on = (phi4 != 4'd0);

        if (ena4) begin
          if ($urandom_range(0, 149) == 0) ena4 = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          ena4 = 1'b1;
        end
        if ($urandom_range(0, 7) == 0) cmp4 = ~cmp4;
        if ($urandom_range(0, 59) == 0) reg4 = ~reg4;
        if ($urandom_range(0, 4) == 0) div4 = 8'($urandom_range(0, 4));
      end
      chk("p4_enough_segments", int'(seg_cnt >= 100), 1);
      chk("p4_run_reached", int'(run_segs >= 20), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
